// File: rtl/capture_pkg.sv
// Shared types and constants for the multi-channel capture controller.
package capture_pkg;

    typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE, DUMP} cap_state_e;

    localparam logic SINGLE = 1'b0;
    localparam logic CONT   = 1'b1;

endpackage

// File: rtl/multi_chan_capture_if.sv
// Trigger, configuration, RAM-address and dump handshake bundle of the capture controller.
interface multi_chan_capture_if #(
    parameter int unsigned NCH  = 5,
    parameter int unsigned LOG2 = 9
) ();

    logic            wrt_smpl;
    logic [NCH-1:0]  chan_trig;
    logic            prot_trig;
    logic [NCH-1:0]  trig_en;
    logic            prot_en;
    logic            trig_and;
    logic            run_mode;
    logic            arm;
    logic            abort;
    logic [LOG2-1:0] trig_pos;
    logic            rd_start;
    logic            rd_next;
    logic            we;
    logic [LOG2-1:0] waddr;
    logic [LOG2-1:0] raddr;
    logic            armed;
    logic            triggered;
    logic            capture_done;
    logic            rd_last;

    modport master (
        output wrt_smpl, chan_trig, prot_trig, trig_en, prot_en, trig_and, run_mode,
        output arm, abort, trig_pos, rd_start, rd_next,
        input  we, waddr, raddr, armed, triggered, capture_done, rd_last
    );

    modport slave (
        input  wrt_smpl, chan_trig, prot_trig, trig_en, prot_en, trig_and, run_mode,
        input  arm, abort, trig_pos, rd_start, rd_next,
        output we, waddr, raddr, armed, triggered, capture_done, rd_last
    );

endinterface

// File: rtl/mod_ptr.sv
// Modulo-DEPTH incrementing pointer with synchronous clear and parallel load.
module mod_ptr #(
    parameter int unsigned DEPTH = 384,
    parameter int unsigned W     = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         ld_i,
    input  logic [W-1:0] ld_val_i,
    input  logic         inc_i,
    output logic [W-1:0] ptr_o
);

    localparam logic [W-1:0] Last = W'(DEPTH - 1);

    logic [W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (ld_i) begin
            ptr_d = ld_val_i;
        end else if (inc_i) begin
            ptr_d = (ptr_q == Last) ? '0 : ptr_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/multi_chan_capture.sv
// Capture control for NCH trigger sources over a circular ENTRIES-deep sample RAM,
// with a programmable post-trigger count, sequenced dump and optional continuous re-arm.
module multi_chan_capture
    import capture_pkg::*;
#(
    parameter int unsigned NCH     = 5,
    parameter int unsigned ENTRIES = 384,
    parameter int unsigned LOG2    = 9
) (
    input logic                 clk,
    input logic                 rst,
    multi_chan_capture_if.slave bus
);

    localparam logic [LOG2-1:0] LastIdx  = LOG2'(ENTRIES - 1);
    localparam logic [LOG2:0]   EntriesW = (LOG2 + 1)'(ENTRIES);

    cap_state_e      state_q, state_d;
    logic [LOG2-1:0] cnt_q, cnt_d, cnt_inc;
    logic [LOG2-1:0] p_q, p_d, p_arm, fill_tgt;
    logic            armed_q, triggered_q, done_q, rd_last_q;
    logic            any_en, hit_or, hit_and, hit;
    logic            we, w_clr, r_ld, r_inc;
    logic [LOG2-1:0] waddr, raddr;

    assign any_en  = (|bus.trig_en) | bus.prot_en;
    assign hit_or  = (|(bus.chan_trig & bus.trig_en)) | (bus.prot_trig & bus.prot_en);
    assign hit_and = (&(bus.chan_trig | ~bus.trig_en)) & (bus.prot_trig | ~bus.prot_en);
    assign hit     = any_en & (bus.trig_and ? hit_and : hit_or);

    always_comb begin
        if (bus.trig_pos == '0) begin
            p_arm = LOG2'(1);
        end else if ({1'b0, bus.trig_pos} >= EntriesW) begin
            p_arm = LastIdx;
        end else begin
            p_arm = bus.trig_pos;
        end
    end

    // Wraps correctly even when ENTRIES == 2**LOG2.
    assign fill_tgt = LOG2'(ENTRIES) - p_q;
    assign cnt_inc  = cnt_q + LOG2'(1);

    assign we = bus.wrt_smpl & ~bus.abort & ~rst &
                ((state_q == PRE) | (state_q == ARMED) | (state_q == POST));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        w_clr   = 1'b0;
        r_ld    = 1'b0;
        r_inc   = 1'b0;
        if (bus.abort) begin
            state_d = IDLE;
            cnt_d   = '0;
            w_clr   = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.arm) begin
                        state_d = PRE;
                        cnt_d   = '0;
                        p_d     = p_arm;
                        w_clr   = 1'b1;
                    end
                end
                PRE: begin
                    if (bus.wrt_smpl) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == fill_tgt) state_d = ARMED;
                    end
                end
                ARMED: begin
                    if (bus.wrt_smpl && hit) begin
                        cnt_d   = LOG2'(1);
                        state_d = (p_q == LOG2'(1)) ? DONE : POST;
                    end
                end
                POST: begin
                    if (bus.wrt_smpl) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == p_q) state_d = DONE;
                    end
                end
                DONE: begin
                    if (bus.arm) begin
                        state_d = PRE;
                        cnt_d   = '0;
                        p_d     = p_arm;
                        w_clr   = 1'b1;
                    end else if (bus.rd_start) begin
                        state_d = DUMP;
                        cnt_d   = '0;
                        r_ld    = 1'b1;
                    end
                end
                DUMP: begin
                    if (bus.rd_start) begin
                        cnt_d = '0;
                        r_ld  = 1'b1;
                    end else if (bus.rd_next) begin
                        r_inc = 1'b1;
                        if (cnt_q == LastIdx) begin
                            cnt_d   = '0;
                            state_d = (bus.run_mode == CONT) ? PRE : DONE;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            p_q         <= LOG2'(1);
            armed_q     <= 1'b0;
            triggered_q <= 1'b0;
            done_q      <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            armed_q     <= (state_d == ARMED);
            triggered_q <= (state_d == POST);
            done_q      <= (state_d == DONE);
            rd_last_q   <= (state_d == DUMP) && (cnt_d == LastIdx);
        end
    end

    mod_ptr #(
        .DEPTH (ENTRIES),
        .W     (LOG2)
    ) u_wptr (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (w_clr),
        .ld_i     (1'b0),
        .ld_val_i ('0),
        .inc_i    (we),
        .ptr_o    (waddr)
    );

    // Dump starts at waddr, which holds the oldest sample once the buffer is frozen.
    mod_ptr #(
        .DEPTH (ENTRIES),
        .W     (LOG2)
    ) u_rptr (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (bus.abort),
        .ld_i     (r_ld),
        .ld_val_i (waddr),
        .inc_i    (r_inc),
        .ptr_o    (raddr)
    );

    assign bus.we           = we;
    assign bus.waddr        = waddr;
    assign bus.raddr        = raddr;
    assign bus.armed        = armed_q;
    assign bus.triggered    = triggered_q;
    assign bus.capture_done = done_q;
    assign bus.rd_last      = rd_last_q;

endmodule

// File: tb/tb_multi_chan_capture.sv
// Directed bench for multi_chan_capture: cycle-level reference model plus literal checkpoints.
module tb_multi_chan_capture;

    localparam int E = 384;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    multi_chan_capture_if #(.NCH(5), .LOG2(9)) bus ();

    multi_chan_capture #(
        .NCH     (5),
        .ENTRIES (E),
        .LOG2    (9)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases named after the operating states, counts kept as plain integers.
    localparam int MI = 0, MP = 1, MA = 2, MT = 3, MD = 4, MU = 5;
    int m_ph = MI, m_p = 1, m_fill = 0, m_post = 0, m_wr = 0, m_rd = 0, m_rcnt = 0;
    bit mv = 1'b0;

    function automatic int eff_p(input int tp);
        if (tp == 0) return 1;
        if (tp >= E) return E - 1;
        return tp;
    endfunction

    function automatic bit m_hit();
        int n_en = 0, n_on = 0;
        for (int c = 0; c < 5; c++) begin
            if (bus.trig_en[c]) begin
                n_en++;
                if (bus.chan_trig[c]) n_on++;
            end
        end
        if (bus.prot_en) begin
            n_en++;
            if (bus.prot_trig) n_on++;
        end
        if (n_en == 0) return 1'b0;
        return bus.trig_and ? (n_on == n_en) : (n_on > 0);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_ph = MI; m_wr = 0; m_rd = 0; m_rcnt = 0; mv = 1'b1;
        end else if (bus.abort) begin
            m_ph = MI; m_wr = 0; m_rd = 0; m_rcnt = 0;
        end else begin
            case (m_ph)
                MI: if (bus.arm) begin
                    m_ph = MP; m_p = eff_p(int'(bus.trig_pos)); m_fill = 0; m_wr = 0;
                end
                MP: if (bus.wrt_smpl) begin
                    m_wr++; m_fill++;
                    if (m_fill == E - m_p) m_ph = MA;
                end
                MA: if (bus.wrt_smpl) begin
                    m_wr++;
                    if (m_hit()) begin
                        m_post = 1;
                        m_ph = (m_p == 1) ? MD : MT;
                    end
                end
                MT: if (bus.wrt_smpl) begin
                    m_wr++; m_post++;
                    if (m_post == m_p) m_ph = MD;
                end
                MD: if (bus.arm) begin
                    m_ph = MP; m_p = eff_p(int'(bus.trig_pos)); m_fill = 0; m_wr = 0;
                end else if (bus.rd_start) begin
                    m_ph = MU; m_rd = m_wr % E; m_rcnt = 0;
                end
                MU: if (bus.rd_start) begin
                    m_rd = m_wr % E; m_rcnt = 0;
                end else if (bus.rd_next) begin
                    m_rd = (m_rd + 1) % E;
                    if (m_rcnt == E - 1) begin
                        m_ph = bus.run_mode ? MP : MD;
                        m_fill = 0;
                    end else begin
                        m_rcnt++;
                    end
                end
                default: m_ph = MI;
            endcase
        end
    end

    always @(negedge clk) begin
        if (mv) begin
            chk("cmp_we", bus.we, !rst && !bus.abort && bus.wrt_smpl &&
                (m_ph == MP || m_ph == MA || m_ph == MT));
            chk("cmp_waddr", bus.waddr, m_wr % E);
            chk("cmp_raddr", bus.raddr, m_rd);
            chk("cmp_armed", bus.armed, m_ph == MA);
            chk("cmp_triggered", bus.triggered, m_ph == MT);
            chk("cmp_done", bus.capture_done, m_ph == MD);
            chk("cmp_rd_last", bus.rd_last, m_ph == MU && m_rcnt == E - 1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
        bus.wrt_smpl = 1'b0; bus.arm = 1'b0; bus.abort = 1'b0;
        bus.rd_start = 1'b0; bus.rd_next = 1'b0;
    endtask

    task automatic writes(input int n);
        for (int i = 0; i < n; i++) begin
            bus.wrt_smpl = 1'b1;
            tick();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_waddr"}, bus.waddr, 0);
        chk({tag, "_raddr"}, bus.raddr, 0);
        chk({tag, "_armed"}, bus.armed, 0);
        chk({tag, "_trig"}, bus.triggered, 0);
        chk({tag, "_done"}, bus.capture_done, 0);
        chk({tag, "_rdlast"}, bus.rd_last, 0);
        chk({tag, "_we"}, bus.we, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        bus.wrt_smpl = 0; bus.chan_trig = '0; bus.prot_trig = 0; bus.trig_en = '0;
        bus.prot_en = 0; bus.trig_and = 0; bus.run_mode = 0; bus.arm = 0; bus.abort = 0;
        bus.trig_pos = '0; bus.rd_start = 0; bus.rd_next = 0;
        bus.wrt_smpl = 1'b1;
        tick(); tick();
        chk_reset_vals("reset");
        rst = 1'b0;

        // OR mode, CH1 held high, P=100; a stray arm mid-PRE must be ignored.
        bus.trig_pos = 9'd100; bus.trig_en = 5'b00001; bus.chan_trig = 5'b00001;
        bus.arm = 1'b1;
        tick();
        for (int k = 1; k <= E; k++) begin
            bus.wrt_smpl = 1'b1;
            if (k == 100) bus.arm = 1'b1;
            #1;
            if (k == 284) begin
                chk("or_armed_before_284", bus.armed, 0);
                chk("or_waddr_283", bus.waddr, 283);
            end
            if (k == 285) begin
                chk("or_armed_at_285", bus.armed, 1);
                chk("or_waddr_284", bus.waddr, 284);
            end
            if (k == E) chk("or_not_done_yet", bus.capture_done, 0);
            tick();
            if (k == 285) chk("or_triggered", bus.triggered, 1);
        end
        chk("or_done", bus.capture_done, 1);
        chk("or_waddr_wrap", bus.waddr, 0);

        // Dump all 384 locations starting from the oldest sample.
        bus.rd_start = 1'b1;
        tick();
        chk("dump_raddr0", bus.raddr, 0);
        for (int i = 1; i <= E; i++) begin
            bus.rd_next = 1'b1;
            tick();
            if (i == 382) chk("dump_rdlast_382", bus.rd_last, 0);
            if (i == 383) begin
                chk("dump_raddr_383", bus.raddr, 383);
                chk("dump_rdlast_383", bus.rd_last, 1);
            end
        end
        chk("dump_back_done", bus.capture_done, 1);
        chk("dump_rdlast_clr", bus.rd_last, 0);

        // AND mode, P=10: no enables never triggers, then prot_trig completes the AND.
        bus.trig_pos = 9'd10; bus.trig_and = 1'b1; bus.trig_en = '0; bus.prot_en = 1'b0;
        bus.chan_trig = 5'b11111; bus.prot_trig = 1'b1; bus.arm = 1'b1;
        tick();
        writes(374);
        chk("and_armed", bus.armed, 1);
        writes(5);
        chk("and_noen_notrig", bus.triggered, 0);
        bus.trig_en = 5'b00110; bus.prot_en = 1'b1; bus.chan_trig = 5'b00110;
        bus.prot_trig = 1'b0;
        writes(5);
        chk("and_prot_low_armed", bus.armed, 1);
        bus.prot_trig = 1'b1;
        tick();
        chk("and_no_wrt_armed", bus.armed, 1);
        writes(1);
        chk("and_triggered", bus.triggered, 1);
        writes(8);
        chk("and_post9_notdone", bus.capture_done, 0);
        writes(1);
        chk("and_done", bus.capture_done, 1);

        // trig_pos=0 behaves as P=1: done the cycle after the trigger write.
        bus.trig_and = 1'b0; bus.trig_en = 5'b00001; bus.prot_en = 1'b0;
        bus.chan_trig = 5'b00001; bus.prot_trig = 1'b0; bus.trig_pos = 9'd0;
        bus.arm = 1'b1;
        tick();
        writes(383);
        chk("p1_armed", bus.armed, 1);
        writes(1);
        chk("p1_done", bus.capture_done, 1);

        // trig_pos=400 clamps to P=383: one pre write, 383 post writes.
        bus.trig_pos = 9'd400; bus.arm = 1'b1;
        tick();
        writes(1);
        chk("p383_armed", bus.armed, 1);
        writes(383);
        chk("p383_done", bus.capture_done, 1);

        // Continuous mode: completing the dump re-arms without an arm pulse.
        bus.run_mode = 1'b1; bus.rd_start = 1'b1;
        tick();
        for (int i = 0; i < E; i++) begin
            bus.rd_next = 1'b1;
            tick();
        end
        chk("cont_pre_not_armed", bus.armed, 0);
        chk("cont_not_done", bus.capture_done, 0);
        writes(1);
        chk("cont_rearmed", bus.armed, 1);

        // Abort mid-POST together with arm and a write: abort wins, we held low.
        bus.run_mode = 1'b0;
        writes(4);
        chk("abort_in_post", bus.triggered, 1);
        bus.abort = 1'b1; bus.arm = 1'b1; bus.wrt_smpl = 1'b1;
        #1;
        chk("abort_we_low", bus.we, 0);
        tick();
        chk_reset_vals("abort");

        // Synchronous reset mid-DUMP.
        bus.trig_pos = 9'd0; bus.arm = 1'b1;
        tick();
        writes(384);
        chk("rst_pre_done", bus.capture_done, 1);
        bus.rd_start = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            bus.rd_next = 1'b1;
            tick();
        end
        chk("rst_in_dump_raddr", bus.raddr, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_reset_vals("rst_dump");
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
